ibex_rvfi_trace_buffer: RTL and testbench

Parametrised on-chip trace capture unit for the Ibex core. It sits beside `ibex_core` on the RVFI retirement bus, in parallel with `ibex_tracer`. It records retired-instruction records into a circular buffer and freezes on a programmable trigger after a configurable number of post-trigger retirements. The captured history is then streamed out oldest-first over a valid/ready port, giving silicon and FPGA builds a trace without the simulation-only text tracer.

---
 rtl/ibex_rvfi_trace_buffer.sv | 180 ++++++++++++++++++
 tb/tb_ibex_rvfi_trace_buffer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_rvfi_trace_buffer.sv
// On-chip RVFI trace capture: circular record buffer that freezes a programmable
// number of retirements after a PC/trap trigger, then streams oldest-first.
module ibex_rvfi_trace_buffer #(
    parameter int unsigned Depth         = 16,
    parameter int unsigned PostTrigDepth = 8,
    parameter bit          CaptureMem    = 1'b0,
    localparam int unsigned RecW         = 105 + (CaptureMem ? 40 : 0),
    localparam int unsigned CntW         = $clog2(Depth) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            arm_i,
    input  logic            trig_pc_en_i,
    input  logic [31:0]     trig_pc_i,
    input  logic            trig_on_trap_i,
    input  logic            rvfi_valid,
    input  logic            rvfi_trap,
    input  logic            rvfi_intr,
    input  logic [31:0]     rvfi_pc_rdata,
    input  logic [31:0]     rvfi_insn,
    input  logic [31:0]     rvfi_rd_wdata,
    input  logic [4:0]      rvfi_rd_addr,
    input  logic [1:0]      rvfi_mode,
    input  logic [31:0]     rvfi_mem_addr,
    input  logic [3:0]      rvfi_mem_rmask,
    input  logic [3:0]      rvfi_mem_wmask,
    output logic            rd_valid_o,
    input  logic            rd_ready_i,
    output logic [RecW-1:0] rd_data_o,
    output logic            rd_last_o,
    output logic [1:0]      state_o,
    output logic [CntW-1:0] count_o,
    output logic            triggered_o,
    output logic            overflow_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e          state_r, state_d_s;
    logic [PtrW-1:0] wr_ptr_r, wr_ptr_d_s;
    logic [PtrW-1:0] rd_ptr_r, rd_ptr_d_s;
    logic [CntW-1:0] count_r, count_d_s;
    logic [CntW-1:0] post_cnt_r, post_cnt_d_s;
    logic            triggered_r, triggered_d_s;
    logic            overflow_r, overflow_d_s;
    logic            capture_s;
    logic            trig_hit_s;
    logic            rd_valid_s;
    logic [RecW-1:0] rec_s;
    logic [RecW-1:0] mem_r [Depth];

    if (CaptureMem) begin : g_rec_mem
        assign rec_s = {rvfi_mem_wmask, rvfi_mem_rmask, rvfi_mem_addr,
                        rvfi_mode, rvfi_intr, rvfi_trap, rvfi_rd_addr,
                        rvfi_rd_wdata, rvfi_insn, rvfi_pc_rdata};
    end else begin : g_rec_nomem
        logic unused_mem_s;
        assign unused_mem_s = ^{rvfi_mem_wmask, rvfi_mem_rmask, rvfi_mem_addr};
        assign rec_s = {rvfi_mode, rvfi_intr, rvfi_trap, rvfi_rd_addr,
                        rvfi_rd_wdata, rvfi_insn, rvfi_pc_rdata};
    end

    assign trig_hit_s = (trig_pc_en_i && (rvfi_pc_rdata == trig_pc_i)) ||
                        (trig_on_trap_i && rvfi_trap);
    assign rd_valid_s = (state_r == ST_DONE) && (count_r != {CntW{1'b0}});

    // Next-state: arm overrides everything, then capture/trigger or readout pop.
    always_comb begin
        state_d_s     = state_r;
        wr_ptr_d_s    = wr_ptr_r;
        rd_ptr_d_s    = rd_ptr_r;
        count_d_s     = count_r;
        post_cnt_d_s  = post_cnt_r;
        triggered_d_s = triggered_r;
        overflow_d_s  = overflow_r;
        capture_s     = 1'b0;
        if (arm_i) begin
            state_d_s     = ST_ARMED;
            wr_ptr_d_s    = {PtrW{1'b0}};
            rd_ptr_d_s    = {PtrW{1'b0}};
            count_d_s     = {CntW{1'b0}};
            post_cnt_d_s  = {CntW{1'b0}};
            triggered_d_s = 1'b0;
            overflow_d_s  = 1'b0;
        end else begin
            case (state_r)
                ST_ARMED, ST_POST: begin
                    if (rvfi_valid) begin
                        capture_s  = 1'b1;
                        wr_ptr_d_s = wr_ptr_r + PtrW'(1);
                        // A full buffer drops its oldest entry to make room.
                        if (count_r == CntW'(Depth)) begin
                            rd_ptr_d_s   = rd_ptr_r + PtrW'(1);
                            overflow_d_s = 1'b1;
                        end else begin
                            count_d_s = count_r + CntW'(1);
                        end
                        if (state_r == ST_ARMED) begin
                            if (trig_hit_s) begin
                                triggered_d_s = 1'b1;
                                if (PostTrigDepth == 0) begin
                                    state_d_s = ST_DONE;
                                end else begin
                                    state_d_s    = ST_POST;
                                    post_cnt_d_s = CntW'(PostTrigDepth);
                                end
                            end else begin
                                state_d_s = state_r;
                            end
                        end else begin
                            post_cnt_d_s = post_cnt_r - CntW'(1);
                            if (post_cnt_r == CntW'(1)) begin
                                state_d_s = ST_DONE;
                            end else begin
                                state_d_s = state_r;
                            end
                        end
                    end else begin
                        capture_s = 1'b0;
                    end
                end
                ST_DONE: begin
                    if (rd_valid_s && rd_ready_i) begin
                        rd_ptr_d_s = rd_ptr_r + PtrW'(1);
                        count_d_s  = count_r - CntW'(1);
                    end else begin
                        count_d_s = count_r;
                    end
                end
                default: begin
                    state_d_s = state_r;
                end
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            wr_ptr_r    <= {PtrW{1'b0}};
            rd_ptr_r    <= {PtrW{1'b0}};
            count_r     <= {CntW{1'b0}};
            post_cnt_r  <= {CntW{1'b0}};
            triggered_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            state_r     <= state_d_s;
            wr_ptr_r    <= wr_ptr_d_s;
            rd_ptr_r    <= rd_ptr_d_s;
            count_r     <= count_d_s;
            post_cnt_r  <= post_cnt_d_s;
            triggered_r <= triggered_d_s;
            overflow_r  <= overflow_d_s;
        end
    end

    // Record storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (capture_s) begin
            mem_r[wr_ptr_r] <= rec_s;
        end
    end

    assign rd_valid_o  = rd_valid_s;
    assign rd_data_o   = mem_r[rd_ptr_r];
    assign rd_last_o   = rd_valid_s && (count_r == CntW'(1));
    assign state_o     = state_r;
    assign count_o     = count_r;
    assign triggered_o = triggered_r;
    assign overflow_o  = overflow_r;

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// Randomised bench for ibex_rvfi_trace_buffer: two instances (post depth 8 without
// memory fields, post depth 0 with memory fields) checked against a list-based model.
module tb_ibex_rvfi_trace_buffer;

    localparam int DEPTH = 16;
    typedef logic [144:0] rec_t;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        arm_i, trig_pc_en_i, trig_on_trap_i;
    logic [31:0] trig_pc_i;
    logic        rvfi_valid, rvfi_trap, rvfi_intr;
    logic [31:0] rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata, rvfi_mem_addr;
    logic [4:0]  rvfi_rd_addr;
    logic [1:0]  rvfi_mode;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
    logic        rd_ready_i;

    logic         rd_valid0, rd_last0, trig0, ovf0;
    logic [104:0] rd_data0;
    logic [1:0]   state0;
    logic [4:0]   count0;
    logic         rd_valid1, rd_last1, trig1, ovf1;
    logic [144:0] rd_data1;
    logic [1:0]   state1;
    logic [4:0]   count1;

    int n_checks = 0;
    int n_errors = 0;

    int   m_st     [2];
    int   m_post   [2];
    int   m_size   [2];
    bit   m_trig   [2];
    bit   m_ovf    [2];
    int   m_pdepth [2] = '{8, 0};
    rec_t m_list   [2][DEPTH];

    always #5 clk = ~clk;

    ibex_rvfi_trace_buffer #(.Depth(16), .PostTrigDepth(8), .CaptureMem(1'b0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_ni), .arm_i(arm_i), .trig_pc_en_i(trig_pc_en_i),
        .trig_pc_i(trig_pc_i), .trig_on_trap_i(trig_on_trap_i), .rvfi_valid(rvfi_valid),
        .rvfi_trap(rvfi_trap), .rvfi_intr(rvfi_intr), .rvfi_pc_rdata(rvfi_pc_rdata),
        .rvfi_insn(rvfi_insn), .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_rd_addr(rvfi_rd_addr),
        .rvfi_mode(rvfi_mode), .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rd_valid_o(rd_valid0), .rd_ready_i(rd_ready_i),
        .rd_data_o(rd_data0), .rd_last_o(rd_last0), .state_o(state0), .count_o(count0),
        .triggered_o(trig0), .overflow_o(ovf0)
    );

    ibex_rvfi_trace_buffer #(.Depth(16), .PostTrigDepth(0), .CaptureMem(1'b1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_ni), .arm_i(arm_i), .trig_pc_en_i(trig_pc_en_i),
        .trig_pc_i(trig_pc_i), .trig_on_trap_i(trig_on_trap_i), .rvfi_valid(rvfi_valid),
        .rvfi_trap(rvfi_trap), .rvfi_intr(rvfi_intr), .rvfi_pc_rdata(rvfi_pc_rdata),
        .rvfi_insn(rvfi_insn), .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_rd_addr(rvfi_rd_addr),
        .rvfi_mode(rvfi_mode), .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rd_valid_o(rd_valid1), .rd_ready_i(rd_ready_i),
        .rd_data_o(rd_data1), .rd_last_o(rd_last1), .state_o(state1), .count_o(count1),
        .triggered_o(trig1), .overflow_o(ovf1)
    );

    task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t cur_rec();
        return {rvfi_mem_wmask, rvfi_mem_rmask, rvfi_mem_addr, rvfi_mode, rvfi_intr,
                rvfi_trap, rvfi_rd_addr, rvfi_rd_wdata, rvfi_insn, rvfi_pc_rdata};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_post[k] = 0; m_size[k] = 0; m_trig[k] = 1'b0; m_ovf[k] = 1'b0;
        end
    endtask

    task automatic model_pop(input int k);
        for (int i = 0; i < DEPTH - 1; i++) m_list[k][i] = m_list[k][i+1];
        m_size[k]--;
    endtask

    // Applies the inputs present at this clock edge to the reference model.
    task automatic model_step();
        bit hit;
        hit = (trig_pc_en_i && rvfi_pc_rdata == trig_pc_i) || (trig_on_trap_i && rvfi_trap);
        for (int k = 0; k < 2; k++) begin
            if (!rst_ni) begin
                model_reset();
            end else if (arm_i) begin
                m_st[k] = 1; m_size[k] = 0; m_trig[k] = 1'b0; m_ovf[k] = 1'b0; m_post[k] = 0;
            end else if ((m_st[k] == 1 || m_st[k] == 2) && rvfi_valid) begin
                if (m_size[k] == DEPTH) begin
                    model_pop(k);
                    m_ovf[k] = 1'b1;
                end
                m_list[k][m_size[k]] = cur_rec();
                m_size[k]++;
                if (m_st[k] == 1) begin
                    if (hit) begin
                        m_trig[k] = 1'b1;
                        m_post[k] = m_pdepth[k];
                        m_st[k]   = (m_pdepth[k] == 0) ? 3 : 2;
                    end
                end else begin
                    m_post[k]--;
                    if (m_post[k] == 0) m_st[k] = 3;
                end
            end else if (m_st[k] == 3 && m_size[k] > 0 && rd_ready_i) begin
                model_pop(k);
            end
        end
    endtask

    task automatic compare_all();
        bit v0, v1;
        v0 = (m_st[0] == 3) && (m_size[0] > 0);
        v1 = (m_st[1] == 3) && (m_size[1] > 0);
        check_eq("u0 state", 160'(state0), 160'(m_st[0]));
        check_eq("u0 count", 160'(count0), 160'(m_size[0]));
        check_eq("u0 triggered", 160'(trig0), 160'(m_trig[0]));
        check_eq("u0 overflow", 160'(ovf0), 160'(m_ovf[0]));
        check_eq("u0 rd_valid", 160'(rd_valid0), 160'(v0));
        check_eq("u0 rd_last", 160'(rd_last0), 160'(v0 && m_size[0] == 1));
        if (v0) check_eq("u0 rd_data", 160'(rd_data0), 160'(m_list[0][0][104:0]));
        check_eq("u1 state", 160'(state1), 160'(m_st[1]));
        check_eq("u1 count", 160'(count1), 160'(m_size[1]));
        check_eq("u1 triggered", 160'(trig1), 160'(m_trig[1]));
        check_eq("u1 overflow", 160'(ovf1), 160'(m_ovf[1]));
        check_eq("u1 rd_valid", 160'(rd_valid1), 160'(v1));
        check_eq("u1 rd_last", 160'(rd_last1), 160'(v1 && m_size[1] == 1));
        if (v1) check_eq("u1 rd_data", 160'(rd_data1), 160'(m_list[1][0]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic randomise_fields();
        rvfi_insn      = $urandom;
        rvfi_rd_wdata  = $urandom;
        rvfi_rd_addr   = 5'($urandom_range(0, 31));
        rvfi_mode      = 2'($urandom_range(0, 3));
        rvfi_intr      = 1'($urandom_range(0, 1));
        rvfi_mem_addr  = $urandom;
        rvfi_mem_rmask = 4'($urandom_range(0, 15));
        rvfi_mem_wmask = 4'($urandom_range(0, 15));
    endtask

    task automatic retire(input logic [31:0] pc, input logic trap);
        randomise_fields();
        rvfi_valid    = 1'b1;
        rvfi_pc_rdata = pc;
        rvfi_trap     = trap;
        tick();
        rvfi_valid    = 1'b0;
    endtask

    task automatic do_arm();
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
    endtask

    task automatic drain(input int cycles);
        rd_ready_i = 1'b1;
        repeat (cycles) tick();
        rd_ready_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; arm_i = 1'b0; trig_pc_en_i = 1'b0; trig_pc_i = 32'h0;
        trig_on_trap_i = 1'b0; rvfi_valid = 1'b0; rvfi_trap = 1'b0; rvfi_pc_rdata = 32'h0;
        rd_ready_i = 1'b0;
        randomise_fields();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_ni = 1'b1;
        tick();

        // Basic capture: 5 pre, trigger at 0x114, 8 post.
        trig_pc_en_i = 1'b1; trig_pc_i = 32'h114;
        do_arm();
        for (int i = 0; i < 14; i++) retire(32'h100 + 32'(4 * i), 1'b0);
        check_eq("basic count", 160'(count0), 160'(14));
        check_eq("basic overflow", 160'(ovf0), 160'(0));
        rd_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 0)  check_eq("basic first pc", 160'(rd_data0[31:0]), 160'(32'h100));
            if (i == 5)  check_eq("basic trig pc", 160'(rd_data0[31:0]), 160'(32'h114));
            if (i == 13) begin
                check_eq("basic last pc", 160'(rd_data0[31:0]), 160'(32'h134));
                check_eq("basic last flag", 160'(rd_last0), 160'(1));
            end
            tick();
        end
        rd_ready_i = 1'b0;

        // Wrap: 30 pre, trigger record 31, 8 post.
        trig_pc_i = 32'h1000 + 32'(4 * 31);
        do_arm();
        for (int i = 1; i <= 39; i++) retire(32'h1000 + 32'(4 * i), 1'b0);
        check_eq("wrap count", 160'(count0), 160'(16));
        check_eq("wrap overflow", 160'(ovf0), 160'(1));
        check_eq("wrap first pc", 160'(rd_data0[31:0]), 160'(32'h1000 + 32'(4 * 24)));
        check_eq("post0 first pc", 160'(rd_data1[31:0]), 160'(32'h1000 + 32'(4 * 16)));
        drain(18);

        // Trap trigger with PC match disabled, then arm in DONE with 5 entries.
        trig_pc_en_i = 1'b0; trig_on_trap_i = 1'b1; trig_pc_i = 32'h2000;
        do_arm();
        retire(32'h2000, 1'b0);
        check_eq("pc ignored", 160'(trig0), 160'(0));
        retire(32'h2004, 1'b1);
        check_eq("trap trigger", 160'(trig0), 160'(1));
        for (int i = 0; i < 8; i++) retire(32'h2008 + 32'(4 * i), 1'b0);
        drain(5);
        check_eq("done five", 160'(count0), 160'(5));
        repeat (4) tick();
        arm_i = 1'b1;
        retire(32'h2000, 1'b1);
        arm_i = 1'b0;
        check_eq("rearm state", 160'(state0), 160'(1));
        check_eq("rearm count", 160'(count0), 160'(0));
        check_eq("rearm trig", 160'(trig0), 160'(0));

        // Reset while in POST.
        trig_on_trap_i = 1'b0; trig_pc_en_i = 1'b1; trig_pc_i = 32'h3000;
        do_arm();
        retire(32'h3000, 1'b0);
        for (int i = 0; i < 3; i++) retire(32'h3004 + 32'(4 * i), 1'b0);
        check_eq("in post", 160'(state0), 160'(2));
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_eq("reset state", 160'(state0), 160'(0));
        check_eq("reset count", 160'(count0), 160'(0));
        check_eq("reset valid", 160'(rd_valid0), 160'(0));
        tick();
        rst_ni = 1'b1;
        tick();

        // Randomised rounds with random backpressure and occasional re-arm.
        for (int r = 0; r < 8; r++) begin
            trig_on_trap_i = 1'($urandom_range(0, 1));
            trig_pc_i = 32'h3000 + 32'(4 * $urandom_range(0, 15));
            do_arm();
            for (int c = 0; c < 60; c++) begin
                randomise_fields();
                rvfi_valid    = ($urandom_range(0, 3) != 0);
                rvfi_pc_rdata = 32'h3000 + 32'(4 * $urandom_range(0, 15));
                rvfi_trap     = ($urandom_range(0, 7) == 0);
                rd_ready_i    = 1'($urandom_range(0, 1));
                arm_i         = ($urandom_range(0, 49) == 0);
                tick();
            end
            rvfi_valid = 1'b0; arm_i = 1'b0;
            drain(20);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
